// File: rtl/data_mem_controller_pkg.sv
// Shared types for the data memory controller: data/address words, the
// controller FSM state encoding and a small index-width helper.
package data_mem_controller_pkg;

    localparam int unsigned DATA_W = 16;
    localparam int unsigned ADDR_W = 8;

    typedef logic [DATA_W-1:0] data_t;
    typedef logic [ADDR_W-1:0] data_memory_address_t;

    typedef enum logic [2:0] {
        DMC_IDLE,
        DMC_READ_WAITING,
        DMC_WRITE_WAITING,
        DMC_READ_RELAYING,
        DMC_WRITE_RELAYING
    } dmc_state_t;

    // Width of a consumer index; never narrower than one bit.
    function automatic int unsigned idx_width(input int unsigned n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/dmc_arbiter.sv
// Combinational grant selection for the data memory controller.
// Macro DMC_ROUND_ROBIN_EN: defined -> rotating priority starting at ptr,
// undefined -> fixed priority (lowest index wins, ptr is ignored).
module dmc_arbiter
    import data_mem_controller_pkg::*;
#(
    parameter int unsigned NUM_CONSUMERS = 4,
    parameter int unsigned IDX_W         = idx_width(NUM_CONSUMERS)
) (
    input  logic [NUM_CONSUMERS-1:0] req,
    input  logic [IDX_W-1:0]         ptr,
    output logic [NUM_CONSUMERS-1:0] grant,
    output logic                     grant_valid
);

`ifdef DMC_ROUND_ROBIN_EN
    logic [IDX_W-1:0] cand;

    // Rotating search: the first requester at or after ptr wins.
    always_comb begin
        grant       = '0;
        grant_valid = 1'b0;
        cand        = '0;
        for (int unsigned k = 0; k < NUM_CONSUMERS; k++) begin
            cand = IDX_W'((32'(ptr) + k) % NUM_CONSUMERS);
            if (!grant_valid && req[cand]) begin
                grant[cand] = 1'b1;
                grant_valid = 1'b1;
            end
        end
    end
`else
    logic unused_ptr;
    assign unused_ptr = ^ptr;

    // Fixed priority: the lowest-index requester wins.
    always_comb begin
        grant       = '0;
        grant_valid = 1'b0;
        for (int unsigned k = 0; k < NUM_CONSUMERS; k++) begin
            if (!grant_valid && req[k]) begin
                grant[k]    = 1'b1;
                grant_valid = 1'b1;
            end
        end
    end
`endif

endmodule

// File: rtl/data_mem_controller.sv
// Data memory controller: serialises load/store requests from several LSU
// consumers onto a single memory port, one transaction at a time.
// Macro DMC_ROUND_ROBIN_EN selects round-robin arbitration (default: fixed
// priority with no pointer state).
module data_mem_controller
    import data_mem_controller_pkg::*;
#(
    parameter int unsigned NUM_CONSUMERS = 4
) (
    input  logic                       clk,
    input  logic                       reset,

    input  logic [NUM_CONSUMERS-1:0]   consumer_read_valid,
    input  data_memory_address_t       consumer_read_address [NUM_CONSUMERS],
    output logic [NUM_CONSUMERS-1:0]   consumer_read_ready,
    output data_t                      consumer_read_data [NUM_CONSUMERS],

    input  logic [NUM_CONSUMERS-1:0]   consumer_write_valid,
    input  data_memory_address_t       consumer_write_address [NUM_CONSUMERS],
    input  data_t                      consumer_write_data [NUM_CONSUMERS],
    output logic [NUM_CONSUMERS-1:0]   consumer_write_ready,

    output logic                       mem_read_valid,
    output data_memory_address_t       mem_read_address,
    input  logic                       mem_read_ready,
    input  data_t                      mem_read_data,

    output logic                       mem_write_valid,
    output data_memory_address_t       mem_write_address,
    output data_t                      mem_write_data,
    input  logic                       mem_write_ready
);

    localparam int unsigned IDX_W = idx_width(NUM_CONSUMERS);

    dmc_state_t               state;
    dmc_state_t               state_next;
    logic [IDX_W-1:0]         cur_idx;
    logic [IDX_W-1:0]         grant_idx;
    logic [IDX_W-1:0]         rr_ptr;
    logic [NUM_CONSUMERS-1:0] req;
    logic [NUM_CONSUMERS-1:0] grant;
    logic                     grant_valid;
    logic                     grant_is_read;
    logic                     take_grant;
    logic                     read_done;
    logic                     write_done;
    logic                     relay_done;

    assign req = consumer_read_valid | consumer_write_valid;

    dmc_arbiter #(
        .NUM_CONSUMERS (NUM_CONSUMERS),
        .IDX_W         (IDX_W)
    ) u_arbiter (
        .req         (req),
        .ptr         (rr_ptr),
        .grant       (grant),
        .grant_valid (grant_valid)
    );

    // Convert the one-hot grant into an index; a consumer asking for both
    // directions is served as a read first.
    always_comb begin
        grant_idx = '0;
        for (int unsigned k = 0; k < NUM_CONSUMERS; k++) begin
            if (grant[k]) begin
                grant_idx = IDX_W'(k);
            end
        end
        grant_is_read = consumer_read_valid[grant_idx];
    end

    // State register.
    always_ff @(posedge clk) begin
        if (reset) begin
            state <= DMC_IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next-state and per-state control strobes.
    always_comb begin
        state_next = state;
        take_grant = 1'b0;
        read_done  = 1'b0;
        write_done = 1'b0;
        relay_done = 1'b0;
        case (state)
            DMC_IDLE: begin
                if (grant_valid) begin
                    take_grant = 1'b1;
                    state_next = grant_is_read ? DMC_READ_WAITING : DMC_WRITE_WAITING;
                end
            end
            DMC_READ_WAITING: begin
                if (mem_read_ready) begin
                    read_done  = 1'b1;
                    state_next = DMC_READ_RELAYING;
                end
            end
            DMC_WRITE_WAITING: begin
                if (mem_write_ready) begin
                    write_done = 1'b1;
                    state_next = DMC_WRITE_RELAYING;
                end
            end
            DMC_READ_RELAYING: begin
                if (!consumer_read_valid[cur_idx]) begin
                    relay_done = 1'b1;
                    state_next = DMC_IDLE;
                end
            end
            DMC_WRITE_RELAYING: begin
                if (!consumer_write_valid[cur_idx]) begin
                    relay_done = 1'b1;
                    state_next = DMC_IDLE;
                end
            end
            default: begin
                state_next = DMC_IDLE;
            end
        endcase
    end

    // Memory-side request registers and latched consumer index.
    always_ff @(posedge clk) begin
        if (reset) begin
            mem_read_valid    <= 1'b0;
            mem_read_address  <= '0;
            mem_write_valid   <= 1'b0;
            mem_write_address <= '0;
            mem_write_data    <= '0;
            cur_idx           <= '0;
        end else begin
            if (take_grant) begin
                cur_idx <= grant_idx;
                if (grant_is_read) begin
                    mem_read_valid   <= 1'b1;
                    mem_read_address <= consumer_read_address[grant_idx];
                end else begin
                    mem_write_valid   <= 1'b1;
                    mem_write_address <= consumer_write_address[grant_idx];
                    mem_write_data    <= consumer_write_data[grant_idx];
                end
            end
            if (read_done) begin
                mem_read_valid <= 1'b0;
            end
            if (write_done) begin
                mem_write_valid <= 1'b0;
            end
        end
    end

    // Consumer-side completion flags and load results; only the consumer
    // being served has its read data updated.
    always_ff @(posedge clk) begin
        if (reset) begin
            consumer_read_ready  <= '0;
            consumer_write_ready <= '0;
            for (int unsigned i = 0; i < NUM_CONSUMERS; i++) begin
                consumer_read_data[i] <= '0;
            end
        end else begin
            if (read_done) begin
                consumer_read_ready[cur_idx] <= 1'b1;
                consumer_read_data[cur_idx]  <= mem_read_data;
            end
            if (write_done) begin
                consumer_write_ready[cur_idx] <= 1'b1;
            end
            if (relay_done) begin
                consumer_read_ready  <= '0;
                consumer_write_ready <= '0;
            end
        end
    end

`ifdef DMC_ROUND_ROBIN_EN
    // Round-robin pointer: next search starts just after the last grant.
    always_ff @(posedge clk) begin
        if (reset) begin
            rr_ptr <= '0;
        end else if (take_grant) begin
            rr_ptr <= (grant_idx == IDX_W'(NUM_CONSUMERS - 1)) ? '0 : grant_idx + 1'b1;
        end
    end
`else
    assign rr_ptr = '0;
`endif

endmodule

// File: tb/tb_data_mem_controller.sv
// Self-checking bench for data_mem_controller: randomized consumer traffic
// and a randomly-delayed memory, checked cycle by cycle against a
// transaction-level expectation. Honours DMC_ROUND_ROBIN_EN like the DUT.
module tb_data_mem_controller;
    import data_mem_controller_pkg::*;

    localparam int unsigned N = 4;

    logic                 clk = 1'b0;
    logic                 reset;
    logic [N-1:0]         consumer_read_valid;
    data_memory_address_t consumer_read_address [N];
    logic [N-1:0]         consumer_read_ready;
    data_t                consumer_read_data [N];
    logic [N-1:0]         consumer_write_valid;
    data_memory_address_t consumer_write_address [N];
    data_t                consumer_write_data [N];
    logic [N-1:0]         consumer_write_ready;
    logic                 mem_read_valid;
    data_memory_address_t mem_read_address;
    logic                 mem_read_ready;
    data_t                mem_read_data;
    logic                 mem_write_valid;
    data_memory_address_t mem_write_address;
    data_t                mem_write_data;
    logic                 mem_write_ready;

    always #5 clk = ~clk;

    data_mem_controller #(.NUM_CONSUMERS(N)) dut (
        .clk                    (clk),
        .reset                  (reset),
        .consumer_read_valid    (consumer_read_valid),
        .consumer_read_address  (consumer_read_address),
        .consumer_read_ready    (consumer_read_ready),
        .consumer_read_data     (consumer_read_data),
        .consumer_write_valid   (consumer_write_valid),
        .consumer_write_address (consumer_write_address),
        .consumer_write_data    (consumer_write_data),
        .consumer_write_ready   (consumer_write_ready),
        .mem_read_valid         (mem_read_valid),
        .mem_read_address       (mem_read_address),
        .mem_read_ready         (mem_read_ready),
        .mem_read_data          (mem_read_data),
        .mem_write_valid        (mem_write_valid),
        .mem_write_address      (mem_write_address),
        .mem_write_data         (mem_write_data),
        .mem_write_ready        (mem_write_ready)
    );

    int checks   = 0;
    int failures = 0;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] want);
        checks++;
        if (got !== want) begin
            failures++;
            $display("FAIL %s got=0x%0h want=0x%0h t=%0t", tag, got, want, $time);
        end
    endtask

    // Transaction progress as seen from outside the controller.
    typedef enum int {T_NONE, T_GRANTED, T_MEM, T_RELAY, T_DONE} tstage_t;

    tstage_t              stage;
    int                   cur;
    bit                   cur_rd;
    int                   lat;
    int                   hold;
    int                   ptr_m;
    int                   force_lat;
    int                   force_hold;
    int                   rand_pct;
    bit                   want_reset;
    bit                   keep_c0;
    int                   served [$];

    logic                 exp_mrv;
    logic                 exp_mwv;
    logic [N-1:0]         exp_crr;
    logic [N-1:0]         exp_cwr;
    data_memory_address_t exp_addr;
    data_t                exp_wdata;
    data_t                exp_rdata [N];
    data_t                mem [256];

    bit                   inj_rd [N];
    bit                   inj_wr [N];
    data_memory_address_t inj_raddr [N];
    data_memory_address_t inj_waddr [N];
    data_t                inj_wdata [N];

    // Arbitration rule applied to the pending set.
    function automatic int pick(input logic [N-1:0] pend);
`ifdef DMC_ROUND_ROBIN_EN
        for (int k = 0; k < int'(N); k++) begin
            if (pend[(ptr_m + k) % int'(N)]) return (ptr_m + k) % int'(N);
        end
`else
        for (int k = 0; k < int'(N); k++) begin
            if (pend[k]) return k;
        end
`endif
        return -1;
    endfunction

    task automatic inject(input int i, input bit rd, input bit wr,
                          input data_memory_address_t ra, input data_memory_address_t wa,
                          input data_t wd);
        inj_rd[i]    = rd;
        inj_wr[i]    = wr;
        inj_raddr[i] = ra;
        inj_waddr[i] = wa;
        inj_wdata[i] = wd;
    endtask

    task automatic clear_expect();
        exp_mrv = 1'b0;
        exp_mwv = 1'b0;
        exp_crr = '0;
        exp_cwr = '0;
        for (int i = 0; i < int'(N); i++) exp_rdata[i] = '0;
        stage = T_NONE;
        ptr_m = 0;
    endtask

    // One clock: compare at the falling edge, then drive the next inputs
    // and work out what the controller must show one cycle later.
    task automatic cycle();
        int           just_dropped;
        int           w;
        int           r;
        bit           busy_i;
        logic [N-1:0] pend;
        @(negedge clk);
        check_eq("mem_read_valid", 32'(mem_read_valid), 32'(exp_mrv));
        check_eq("mem_write_valid", 32'(mem_write_valid), 32'(exp_mwv));
        check_eq("consumer_read_ready", 32'(consumer_read_ready), 32'(exp_crr));
        check_eq("consumer_write_ready", 32'(consumer_write_ready), 32'(exp_cwr));
        if (exp_mrv) check_eq("mem_read_address", 32'(mem_read_address), 32'(exp_addr));
        if (exp_mwv) begin
            check_eq("mem_write_address", 32'(mem_write_address), 32'(exp_addr));
            check_eq("mem_write_data", 32'(mem_write_data), 32'(exp_wdata));
        end
        for (int i = 0; i < int'(N); i++)
            check_eq($sformatf("consumer_read_data%0d", i), 32'(consumer_read_data[i]), 32'(exp_rdata[i]));

        mem_read_ready  = 1'b0;
        mem_write_ready = 1'b0;
        mem_read_data   = data_t'($urandom);
        reset           = 1'b0;
        if (want_reset) begin
            want_reset           = 1'b0;
            reset                = 1'b1;
            keep_c0              = 1'b0;
            consumer_read_valid  = '0;
            consumer_write_valid = '0;
            for (int i = 0; i < int'(N); i++) begin
                inj_rd[i] = 1'b0;
                inj_wr[i] = 1'b0;
            end
            clear_expect();
            return;
        end

        just_dropped = -1;
        case (stage)
            T_GRANTED, T_MEM: begin
                stage = T_MEM;
                if (lat == 0) begin
                    if (cur_rd) begin
                        mem_read_ready = 1'b1;
                        mem_read_data  = mem[exp_addr];
                        exp_mrv        = 1'b0;
                        exp_crr[cur]   = 1'b1;
                        exp_rdata[cur] = mem[exp_addr];
                    end else begin
                        mem_write_ready = 1'b1;
                        mem[exp_addr]   = exp_wdata;
                        exp_mwv         = 1'b0;
                        exp_cwr[cur]    = 1'b1;
                    end
                    served.push_back(cur * 2 + (cur_rd ? 0 : 1));
                    stage = T_RELAY;
                end else begin
                    lat--;
                end
            end
            T_RELAY: begin
                if (hold > 0) begin
                    hold--;
                end else begin
                    if (cur_rd) consumer_read_valid[cur] = 1'b0;
                    else        consumer_write_valid[cur] = 1'b0;
                    exp_crr      = '0;
                    exp_cwr      = '0;
                    just_dropped = cur;
                    stage        = T_DONE;
                end
            end
            T_DONE: stage = T_NONE;
            default: ;
        endcase

        // Consumers with nothing outstanding may post a new request.
        for (int i = 0; i < int'(N); i++) begin
            busy_i = consumer_read_valid[i] || consumer_write_valid[i] || exp_crr[i] || exp_cwr[i];
            if (!busy_i && i != just_dropped) begin
                if (keep_c0 && i == 0) begin
                    consumer_read_valid[0]   = 1'b1;
                    consumer_read_address[0] = data_memory_address_t'($urandom);
                end else if (inj_rd[i] || inj_wr[i]) begin
                    consumer_read_valid[i]    = inj_rd[i];
                    consumer_write_valid[i]   = inj_wr[i];
                    consumer_read_address[i]  = inj_raddr[i];
                    consumer_write_address[i] = inj_waddr[i];
                    consumer_write_data[i]    = inj_wdata[i];
                    inj_rd[i] = 1'b0;
                    inj_wr[i] = 1'b0;
                end else if ($urandom_range(99) < rand_pct) begin
                    r = $urandom_range(2);
                    consumer_read_valid[i]    = (r != 1);
                    consumer_write_valid[i]   = (r != 0);
                    consumer_read_address[i]  = data_memory_address_t'($urandom);
                    consumer_write_address[i] = data_memory_address_t'($urandom);
                    consumer_write_data[i]    = data_t'($urandom);
                end
            end
        end

        if (stage == T_NONE) begin
            pend = consumer_read_valid | consumer_write_valid;
            if (pend != '0) begin
                w      = pick(pend);
                cur    = w;
                cur_rd = consumer_read_valid[w];
                if (cur_rd) begin
                    exp_mrv  = 1'b1;
                    exp_addr = consumer_read_address[w];
                end else begin
                    exp_mwv   = 1'b1;
                    exp_addr  = consumer_write_address[w];
                    exp_wdata = consumer_write_data[w];
                end
                lat   = (force_lat  >= 0) ? force_lat  : int'($urandom_range(3));
                hold  = (force_hold >= 0) ? force_hold : int'($urandom_range(3));
                ptr_m = (w + 1) % int'(N);
                stage = T_GRANTED;
            end
        end
    endtask

    function automatic bit all_quiet();
        bit q;
        q = (stage == T_NONE) && (consumer_read_valid == '0) && (consumer_write_valid == '0) && !keep_c0;
        for (int i = 0; i < int'(N); i++) q = q && !inj_rd[i] && !inj_wr[i];
        return q;
    endfunction

    task automatic drain(input string tag, input int budget);
        bit idle_seen;
        idle_seen = 1'b0;
        for (int c = 0; c < budget && !idle_seen; c++) begin
            cycle();
            idle_seen = all_quiet();
        end
        check_eq({tag, "_drain"}, 32'(idle_seen), 32'd1);
    endtask

    task automatic do_reset();
        want_reset = 1'b1;
        cycle();
        cycle();
    endtask

    int count3;
    bit reached;

    initial begin
        reset                = 1'b1;
        consumer_read_valid  = '0;
        consumer_write_valid = '0;
        mem_read_ready       = 1'b0;
        mem_write_ready      = 1'b0;
        mem_read_data        = '0;
        for (int i = 0; i < int'(N); i++) begin
            consumer_read_address[i]  = '0;
            consumer_write_address[i] = '0;
            consumer_write_data[i]    = '0;
            inj_rd[i] = 1'b0;
            inj_wr[i] = 1'b0;
        end
        for (int a = 0; a < 256; a++) mem[a] = data_t'($urandom);
        clear_expect();
        force_lat  = -1;
        force_hold = -1;
        rand_pct   = 0;
        want_reset = 1'b0;
        keep_c0    = 1'b0;

        repeat (3) @(negedge clk);
        check_eq("rst_mem_read_address", 32'(mem_read_address), 32'd0);
        check_eq("rst_mem_write_address", 32'(mem_write_address), 32'd0);
        check_eq("rst_mem_write_data", 32'(mem_write_data), 32'd0);
        repeat (3) cycle();

        // Single read: consumer 2, address 0x10, memory answers after 3 cycles.
        mem[8'h10] = 16'h1234;
        force_lat  = 3;
        force_hold = 0;
        inject(2, 1'b1, 1'b0, 8'h10, 8'h00, 16'h0000);
        drain("single_read", 40);
        check_eq("single_read_data", 32'(consumer_read_data[2]), 32'h1234);

        // Single write: consumer 0, address 0x05, data 0x00AB.
        force_lat = 1;
        inject(0, 1'b0, 1'b1, 8'h00, 8'h05, 16'h00AB);
        drain("single_write", 40);

        // Contention: all four read together, twice, from a fresh pointer.
        do_reset();
        force_lat  = -1;
        force_hold = -1;
        for (int burst = 0; burst < 2; burst++) begin
            served.delete();
            for (int i = 0; i < int'(N); i++)
                inject(i, 1'b1, 1'b0, data_memory_address_t'($urandom), 8'h00, 16'h0000);
            drain($sformatf("burst%0d", burst), 120);
            check_eq($sformatf("burst%0d_count", burst), 32'(served.size()), 32'd4);
            for (int i = 0; i < int'(N) && i < served.size(); i++)
                check_eq($sformatf("burst%0d_order%0d", burst, i), 32'(served[i]), 32'(i * 2));
        end

        // Consumer 0 re-requesting continuously while 1..3 wait.
        do_reset();
        force_lat  = 0;
        force_hold = 0;
        served.delete();
        keep_c0 = 1'b1;
        for (int i = 1; i < int'(N); i++)
            inject(i, 1'b1, 1'b0, data_memory_address_t'($urandom), 8'h00, 16'h0000);
        repeat (80) cycle();
        count3 = 0;
        foreach (served[k]) if (served[k] == 6) count3++;
`ifdef DMC_ROUND_ROBIN_EN
        check_eq("c3_served_under_rr", 32'(count3 > 0), 32'd1);
`else
        check_eq("c3_starved_fixed", 32'(count3), 32'd0);
`endif
        keep_c0 = 1'b0;
        drain("starve", 200);

        // Consumer 1 asks for a read and a write at once: read goes first.
        force_lat  = -1;
        force_hold = -1;
        served.delete();
        inject(1, 1'b1, 1'b1, 8'h22, 8'h33, 16'hBEEF);
        drain("rd_wr_same", 60);
        check_eq("rd_wr_count", 32'(served.size()), 32'd2);
        if (served.size() == 2) begin
            check_eq("rd_wr_first", 32'(served[0]), 32'd2);
            check_eq("rd_wr_second", 32'(served[1]), 32'd3);
        end

        // Relay hold: ready must persist while the consumer keeps valid high,
        // with another requester waiting.
        force_hold = 5;
        inject(3, 1'b1, 1'b0, 8'h44, 8'h00, 16'h0000);
        inject(1, 1'b0, 1'b1, 8'h00, 8'h55, 16'h5A5A);
        drain("relay_hold", 80);
        force_hold = -1;

        // Reset while a read waits on memory: no completion may follow.
        force_lat = 1000;
        inject(2, 1'b1, 1'b0, 8'h10, 8'h00, 16'h0000);
        reached = 1'b0;
        for (int c = 0; c < 20 && !reached; c++) begin
            cycle();
            reached = (stage == T_MEM);
        end
        check_eq("reach_read_waiting", 32'(reached), 32'd1);
        want_reset = 1'b1;
        cycle();
        force_lat = -1;
        repeat (6) cycle();

        // Randomized traffic.
        rand_pct = 30;
        repeat (2000) cycle();
        rand_pct = 0;
        drain("random", 300);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/data_mem_controller.md
DATA_MEM_CONTROLLER -- requirements
Module: data_mem_controller

Interface
REQ-001 SHALL have parameter NUM_CONSUMERS, default 4, number of LSU requesters served.
REQ-002 SHALL have port clk  input  1  single clock; all logic on posedge clk.
REQ-003 SHALL have port reset  input  1  synchronous, active-high reset.
REQ-004 SHALL have ports consumer_read_valid / consumer_write_valid  input  [NUM_CONSUMERS]  per-LSU request strobes.
REQ-005 SHALL have ports consumer_read_address / consumer_write_address  input  [NUM_CONSUMERS] x data_memory_address_t  request addresses.
REQ-006 SHALL have port consumer_write_data  input  [NUM_CONSUMERS] x data_t  store data.
REQ-007 SHALL have ports consumer_read_ready / consumer_write_ready  output  [NUM_CONSUMERS]  per-LSU completion.
REQ-008 SHALL have port consumer_read_data  output  [NUM_CONSUMERS] x data_t  load result.
REQ-009 SHALL have ports mem_read_valid, mem_write_valid  output  1; mem_read_address, mem_write_address  output  data_memory_address_t; mem_write_data  output  data_t.
REQ-010 SHALL have ports mem_read_ready, mem_write_ready  input  1; mem_read_data  input  data_t.

Function
REQ-011 SHALL be a 5-state FSM: DMC_IDLE, DMC_READ_WAITING, DMC_WRITE_WAITING, DMC_READ_RELAYING, DMC_WRITE_RELAYING.
REQ-012 SHALL, in IDLE, grant one consumer with read_valid or write_valid high; read wins over write when one consumer asserts both.
REQ-013 SHALL, on grant, register mem_*_valid=1 plus address (and data for writes) from the granted consumer, latch the consumer index, and enter *_WAITING the next cycle (one-cycle request latency).
REQ-014 SHALL, in *_WAITING on mem_*_ready=1, drop mem_*_valid, assert consumer_*_ready[idx]=1 (and capture mem_read_data into consumer_read_data[idx] for reads), enter *_RELAYING.
REQ-015 SHALL hold consumer_*_ready[idx] high in *_RELAYING until consumer_*_valid[idx] is low, then clear ready and return to IDLE; no new grant in the same cycle.
REQ-016 SHALL keep consumer_read_data[i] stable for every consumer not currently being relayed.
REQ-017 SHALL ignore consumer valid changes of non-granted consumers while busy; their requests remain pending.
REQ-018 SHALL never assert mem_read_valid and mem_write_valid simultaneously, and at most one consumer ready bit at any time.
REQ-019 SHALL stay in IDLE with all outputs idle when no consumer valid is high.

Reset
REQ-020 SHALL, on reset, force IDLE, all mem_*_valid=0, addresses/data=0, all consumer_*_ready=0, all consumer_read_data=0, round-robin pointer=0.
REQ-021 SHALL abandon any in-flight transaction on reset mid-operation; no ready pulse issues afterwards for it.

Configuration
REQ-022 SHALL honour macro DMC_ROUND_ROBIN_EN: defined -> round-robin grant starting at (last granted index + 1) mod NUM_CONSUMERS; undefined -> fixed priority, lowest index wins, pointer logic absent.

Structure
REQ-023 SHALL place dmc_state_t enum in the shared package alongside data_t and data_memory_address_t.
REQ-024 SHALL implement grant selection in one sub-module dmc_arbiter (request vector + pointer in, one-hot grant + valid out, combinational).

Verification
REQ-025 Single read: consumer 2 read addr 0x10, memory returns 0x1234 after 3 cycles -> mem_read_valid 1 cycle after request, consumer_read_ready[2]=1, consumer_read_data[2]=0x1234; clears one cycle after valid drops.
REQ-026 Single write: consumer 0 write addr 0x05 data 0x00AB -> mem_write_address=0x05, mem_write_data=0x00AB, consumer_write_ready[0] pulses until valid drops.
REQ-027 Contention: consumers 0..3 all read at once -> with DMC_ROUND_ROBIN_EN served 0,1,2,3; second burst served 0,1,2,3 again; without macro, consumer 0 re-requesting starves 3.
REQ-028 Read+write same consumer: consumer 1 asserts both -> read served first, then write.
REQ-029 Reset during READ_WAITING -> next cycle state IDLE, mem_read_valid=0, no consumer_read_ready pulse.
REQ-030 Relay hold: consumer keeps valid high 5 cycles after ready -> ready stays high 5 cycles, no other grant meanwhile.
